// File: rtl/useq_pkg.sv
// useq_pkg: shared types and constants for the microprogram sequencer.
//   state_t       sequencer states
//   DISPATCH_BASE first control-store word of the opcode dispatch table
//   STACK_DEPTH   depth of the optional micro-subroutine return stack
//   M2_CALL/RET   m2 field encodings for call/return (used only when
//                 USEQ_CALL_STACK_EN is defined)
package useq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int DISPATCH_BASE = 16;
    localparam int STACK_DEPTH   = 4;

    localparam logic [2:0] M2_CALL = 3'b111;
    localparam logic [2:0] M2_RET  = 3'b110;

endpackage

// File: rtl/useq_stack.sv
// useq_stack: small LIFO of return addresses for micro-subroutine calls.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (clears pointer+storage)
//   push, pop    push din / drop top entry (caller never asserts both,
//                and never pushes when full or pops when empty)
//   din          value to push
//   dout         current top of stack (meaningless when empty)
//   full, empty  occupancy flags
module useq_stack #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [SP_W-1:0]         sp;    // number of valid entries

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign dout  = mem[IDX_W'(sp - SP_W'(1))];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp  <= '0;
            mem <= '0;
        end else if (push) begin
            mem[IDX_W'(sp)] <= din;
            sp              <= sp + SP_W'(1);
        end else if (pop) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/useq.sv
// useq: microprogram sequencer. Computes the next control-store address
// from the microinstruction fields, ALU zero flag and opcode; handles
// start-up, memory stalls and halt (self-jump) detection.
// Optional feature: define USEQ_CALL_STACK_EN to add a 4-deep call/return
// stack decoded from the m2 field; otherwise m2 is ignored and stack_err
// is tied low.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        one-cycle pulse, leaves IDLE
//   stall        memory not ready, hold micro-PC
//   addr, bt, cond_sel, m2   microinstruction fields
//   flag_z       ALU zero flag
//   opcode       instruction opcode for dispatch
//   upc          control-store address (registered)
//   running      high in RUN or WAIT
//   halted       high in HALT
//   ucycles      saturating count of executed microinstructions
//   stack_err    sticky stack overflow/underflow
module useq
    import useq_pkg::*;
#(
    parameter int UPC_W = 5,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [UPC_W-1:0] addr,
    input  logic             bt,
    input  logic             cond_sel,
    input  logic [2:0]       m2,
    input  logic             flag_z,
    input  logic [OP_W-1:0]  opcode,
    output logic [UPC_W-1:0] upc,
    output logic             running,
    output logic             halted,
    output logic [15:0]      ucycles,
    output logic             stack_err
);

    state_t           state, state_nx;
    logic [UPC_W-1:0] upc_q, upc_nx, upc_inc, target, disp;
    logic [15:0]      uc_q;
    logic             running_q, halted_q;
    logic             adv;        // sequencer steps this cycle (not stalled)
    logic             halt_hit;
    logic             is_call, is_ret;
    logic             stk_push, stk_pop, stk_full, stk_empty;
    logic [UPC_W-1:0] stk_top;
    logic             err_set;

    assign upc_inc = upc_q + UPC_W'(1);   // wraps at the top of the store
    assign disp    = UPC_W'(DISPATCH_BASE) + UPC_W'(opcode);

`ifdef USEQ_CALL_STACK_EN
    logic err_q;

    assign is_call = !bt && (m2 == M2_CALL);
    assign is_ret  = !bt && (m2 == M2_RET);

    useq_stack #(
        .W     (UPC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (upc_inc),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)       err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign stack_err = err_q;
`else
    logic m2_unused;

    assign is_call   = 1'b0;
    assign is_ret    = 1'b0;
    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_top   = '0;
    assign m2_unused = ^{m2, stk_push, stk_pop, err_set};
    assign stack_err = 1'b0;
`endif

    // A plain jump to its own address is the halt idiom.
    assign halt_hit = !bt && !is_call && !is_ret && (addr == upc_q);
    assign adv      = ((state == RUN) || (state == WAIT)) && !stall;

    always_comb begin
        target = addr;
        if (bt) begin
            if (cond_sel) target = flag_z ? addr : upc_inc;
            else          target = disp;
        end else if (is_ret) begin
            target = stk_empty ? '0 : stk_top;
        end
    end

    always_comb begin
        state_nx = state;
        upc_nx   = upc_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                upc_nx = '0;
                if (start) state_nx = RUN;
            end
            RUN, WAIT: begin
                // stall outranks halt detection and branching
                if (stall)         state_nx = WAIT;
                else if (halt_hit) state_nx = HALT;
                else begin
                    state_nx = RUN;
                    upc_nx   = target;
                    stk_push = is_call && !stk_full;
                    stk_pop  = is_ret && !stk_empty;
                    err_set  = (is_call && stk_full) || (is_ret && stk_empty);
                end
            end
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            upc_q     <= '0;
            uc_q      <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            upc_q     <= upc_nx;
            running_q <= (state_nx == RUN) || (state_nx == WAIT);
            halted_q  <= (state_nx == HALT);
            if (adv && !halt_hit && (uc_q != 16'hFFFF))
                uc_q <= uc_q + 16'd1;
        end
    end

    assign upc     = upc_q;
    assign running = running_q;
    assign halted  = halted_q;
    assign ucycles = uc_q;

endmodule

// File: tb/tb_useq.sv
module tb_useq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stall = 1'b0;
    logic [4:0] addr = '0;
    logic       bt = 1'b0, cond_sel = 1'b0, flag_z = 1'b0;
    logic [2:0] m2 = '0;
    logic [3:0] opcode = '0;
    logic [4:0] upc;
    logic       running, halted, stack_err;
    logic [15:0] ucycles;

    int n_chk = 0;
    int n_err = 0;

    useq #(.UPC_W(5), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .addr(addr), .bt(bt), .cond_sel(cond_sel), .m2(m2),
        .flag_z(flag_z), .opcode(opcode), .upc(upc), .running(running),
        .halted(halted), .ucycles(ucycles), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bt, cs;
        logic [2:0] m2;
        logic [4:0] addr;
        logic [3:0] op;
        logic       fz, st, sta;
        logic [4:0] e_upc;
        logic       e_run, e_halt;
        int         e_uc;     // -1: not checked
        logic       e_err;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic b, logic c, logic [2:0] m, logic [4:0] a,
                                logic [3:0] o, logic z, logic s, logic sa,
                                logic [4:0] eu, logic er, logic eh, int euc,
                                logic ee);
        vec_t v;
        v.bt = b; v.cs = c; v.m2 = m; v.addr = a; v.op = o; v.fz = z;
        v.st = s; v.sta = sa; v.e_upc = eu; v.e_run = er; v.e_halt = eh;
        v.e_uc = euc; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle's fields on negedge, queue the expectation, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        bt = v.bt; cond_sel = v.cs; m2 = v.m2; addr = v.addr; opcode = v.op;
        flag_z = v.fz; stall = v.st; start = v.sta;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " upc"}, 32'(upc), 32'(e.e_upc));
        chk({tag, " running"}, 32'(running), 32'(e.e_run));
        chk({tag, " halted"}, 32'(halted), 32'(e.e_halt));
        chk({tag, " stack_err"}, 32'(stack_err), 32'(e.e_err));
        if (e.e_uc >= 0) chk({tag, " ucycles"}, 32'(ucycles), 32'(e.e_uc));
    endtask

    // Reset asserted for one edge with a self-jump on the fields; reset must win.
    task automatic reset_chk(input string tag);
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; bt = 1'b0; addr = upc; m2 = '0;
        @(posedge clk);
        #1;
        chk({tag, " upc"}, 32'(upc), 0);
        chk({tag, " running"}, 32'(running), 0);
        chk({tag, " halted"}, 32'(halted), 0);
        chk({tag, " ucycles"}, 32'(ucycles), 0);
        chk({tag, " stack_err"}, 32'(stack_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_pulse(input string tag);
        @(negedge clk);
        start = 1'b1; bt = 1'b1; cond_sel = 1'b0; opcode = 4'h3; stall = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " running"}, 32'(running), 1);
        chk({tag, " upc"}, 32'(upc), 0);
        chk({tag, " ucycles"}, 32'(ucycles), 0);
    endtask

    initial begin
        // main table, starting from RUN at upc=0
        //             bt cs m2    addr   op    fz st sa  e_upc  run hlt uc err
        tbl.push_back(mk(1, 0, 3'd0, 5'd0,  4'hA, 0, 0, 0, 5'd26, 1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 3'd0, 5'd3,  4'h0, 0, 0, 0, 5'd27, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd31, 4'h0, 0, 0, 0, 5'd31, 1, 0, 3, 0));
        tbl.push_back(mk(1, 1, 3'd0, 5'd5,  4'h0, 1, 0, 0, 5'd5,  1, 0, 4, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd31, 4'h0, 0, 0, 0, 5'd31, 1, 0, 5, 0));
        tbl.push_back(mk(1, 1, 3'd0, 5'd5,  4'h0, 0, 0, 0, 5'd0,  1, 0, 6, 0));
        tbl.push_back(mk(1, 0, 3'd0, 5'd0,  4'hF, 0, 0, 0, 5'd31, 1, 0, 7, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd7,  4'h0, 0, 0, 0, 5'd7,  1, 0, 8, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd20, 4'h0, 0, 1, 0, 5'd7,  1, 0, 8, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd20, 4'h0, 0, 1, 0, 5'd7,  1, 0, 8, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd20, 4'h0, 0, 1, 0, 5'd7,  1, 0, 8, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd12, 4'h0, 0, 0, 0, 5'd12, 1, 0, 9, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd12, 4'h0, 0, 1, 0, 5'd12, 1, 0, 9, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd12, 4'h0, 0, 1, 0, 5'd12, 1, 0, 9, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd12, 4'h0, 0, 0, 0, 5'd12, 0, 1, -1, 0));
        tbl.push_back(mk(0, 0, 3'd0, 5'd3,  4'h0, 0, 0, 1, 5'd12, 0, 1, -1, 0));
        tbl.push_back(mk(1, 0, 3'd0, 5'd0,  4'h1, 0, 0, 0, 5'd12, 0, 1, -1, 0));

        repeat (2) @(posedge clk);
        reset_chk("reset");
        start_pulse("start");
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // reset clears HALT; then reset mid-RUN at upc=9
        reset_chk("reset_halt");
        start_pulse("start2");
        apply(mk(0, 0, 3'd0, 5'd9, 4'h0, 0, 0, 0, 5'd9, 1, 0, 1, 0), "jump9");
        reset_chk("reset_mid");

`ifdef USEQ_CALL_STACK_EN
        start_pulse("start_stk");
        apply(mk(0, 0, 3'd0, 5'd3,  4'h0, 0, 0, 0, 5'd3,  1, 0, 1, 0), "to3");
        apply(mk(0, 0, 3'd7, 5'd20, 4'h0, 0, 0, 0, 5'd20, 1, 0, 2, 0), "call20");
        apply(mk(0, 0, 3'd6, 5'd0,  4'h0, 0, 0, 0, 5'd4,  1, 0, 3, 0), "ret4");
        for (int i = 0; i < 4; i++)
            apply(mk(0, 0, 3'd7, 5'(10 + i), 4'h0, 0, 0, 0, 5'(10 + i), 1, 0, -1, 0),
                  $sformatf("ncall%0d", i));
        apply(mk(0, 0, 3'd7, 5'd14, 4'h0, 0, 0, 0, 5'd14, 1, 0, -1, 1), "ncall_ovf");
        apply(mk(0, 0, 3'd6, 5'd0,  4'h0, 0, 0, 0, 5'd13, 1, 0, -1, 1), "nret0");
        apply(mk(0, 0, 3'd6, 5'd0,  4'h0, 0, 0, 0, 5'd12, 1, 0, -1, 1), "nret1");
        apply(mk(0, 0, 3'd6, 5'd0,  4'h0, 0, 0, 0, 5'd11, 1, 0, -1, 1), "nret2");
        apply(mk(0, 0, 3'd6, 5'd0,  4'h0, 0, 0, 0, 5'd5,  1, 0, -1, 1), "nret3");
        reset_chk("reset_stk");
        start_pulse("start_unf");
        apply(mk(0, 0, 3'd0, 5'd6,  4'h0, 0, 0, 0, 5'd6,  1, 0, 1, 0), "to6");
        apply(mk(0, 0, 3'd6, 5'd9,  4'h0, 0, 0, 0, 5'd0,  1, 0, 2, 1), "ret_empty");
        apply(mk(0, 0, 3'd0, 5'd8,  4'h0, 0, 0, 0, 5'd8,  1, 0, 3, 1), "err_sticky");
`else
        // m2 ignored: call/return encodings behave as plain jumps and halts
        start_pulse("start_m2");
        apply(mk(0, 0, 3'd7, 5'd20, 4'h0, 0, 0, 0, 5'd20, 1, 0, 1, 0), "m2_call_jump");
        apply(mk(0, 0, 3'd6, 5'd20, 4'h0, 0, 0, 0, 5'd20, 0, 1, -1, 0), "m2_ret_halt");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
